// File: rtl/ex_operand_stage.sv
// EX-stage operand register: resolves forwarded ALU operands, stalls one cycle on
// load-use hazards, and presents registered operands over a valid/ready handshake.
module ex_operand_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      id_ex_rs1,
  input  logic [4:0]      id_ex_rs2,
  input  logic [XLEN-1:0] id_ex_rs1_data,
  input  logic [XLEN-1:0] id_ex_rs2_data,
  input  logic [XLEN-1:0] id_ex_imm,
  input  logic            id_ex_use_imm,
  input  logic [4:0]      id_ex_rd,
  input  logic [1:0]      rs1_forward,
  input  logic [1:0]      rs2_forward,
  input  logic [XLEN-1:0] ex_mem_result,
  input  logic            ex_mem_is_load,
  input  logic [XLEN-1:0] mem_wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ex_op_a,
  output logic [XLEN-1:0] ex_op_b,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_rd,
  output logic            load_stall
);

  typedef enum logic [0:0] {StRun, StLdWait} state_e;

  state_e          r_state, w_state_nxt;
  logic            r_dep1, r_dep2, w_dep1_nxt, w_dep2_nxt;
  logic            r_out_valid;
  logic [XLEN-1:0] r_op_a, r_op_b, r_store_data;
  logic [4:0]      r_rd;

  logic            w_hz1, w_hz2, w_can_load, w_accept;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val;

  // x0 always reads the register file, regardless of the forwarding select.
  function automatic logic [XLEN-1:0] fwd_pick(input logic [4:0]      idx,
                                               input logic [1:0]      sel,
                                               input logic [XLEN-1:0] rf,
                                               input logic [XLEN-1:0] exm,
                                               input logic [XLEN-1:0] wb);
    if (idx == 5'd0) return rf;
    case (sel)
      2'b01:   return exm;
      2'b10:   return wb;
      default: return rf;
    endcase
  endfunction

  always_comb begin
    w_hz1 = in_valid & (rs1_forward == 2'b01) & ex_mem_is_load & (id_ex_rs1 != 5'd0);
    w_hz2 = in_valid & (rs2_forward == 2'b01) & ex_mem_is_load & (id_ex_rs2 != 5'd0);
    w_can_load = !r_out_valid | out_ready;

    w_rs1_val = fwd_pick(id_ex_rs1, rs1_forward, id_ex_rs1_data, ex_mem_result, mem_wb_data);
    w_rs2_val = fwd_pick(id_ex_rs2, rs2_forward, id_ex_rs2_data, ex_mem_result, mem_wb_data);
    // While waiting, the load result has arrived at MEM/WB for dependent operands.
    if (r_state == StLdWait && r_dep1) w_rs1_val = mem_wb_data;
    if (r_state == StLdWait && r_dep2) w_rs2_val = mem_wb_data;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dep1_nxt  = r_dep1;
    w_dep2_nxt  = r_dep2;
    in_ready    = 1'b0;
    load_stall  = 1'b0;
    if (!rst) begin
      w_state_nxt = StRun;
      w_dep1_nxt  = 1'b0;
      w_dep2_nxt  = 1'b0;
    end else if (flush) begin
      w_state_nxt = StRun;
      w_dep1_nxt  = 1'b0;
      w_dep2_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (w_hz1 | w_hz2) begin
            load_stall  = 1'b1;
            w_dep1_nxt  = w_hz1;
            w_dep2_nxt  = w_hz2;
            w_state_nxt = StLdWait;
          end else begin
            in_ready = w_can_load;
          end
        end
        StLdWait: begin
          if (w_can_load) begin
            in_ready    = 1'b1;
            w_dep1_nxt  = 1'b0;
            w_dep2_nxt  = 1'b0;
            w_state_nxt = StRun;
          end else begin
            load_stall = 1'b1;
          end
        end
      endcase
    end
  end

  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= StRun;
      r_dep1       <= 1'b0;
      r_dep2       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_store_data <= '0;
      r_rd         <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dep1  <= w_dep1_nxt;
      r_dep2  <= w_dep2_nxt;
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid  <= 1'b1;
        r_op_a       <= w_rs1_val;
        r_op_b       <= id_ex_use_imm ? id_ex_imm : w_rs2_val;
        r_store_data <= w_rs2_val;
        r_rd         <= id_ex_rd;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign ex_op_a       = r_op_a;
  assign ex_op_b       = r_op_b;
  assign ex_store_data = r_store_data;
  assign ex_rd         = r_rd;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed literal checks plus randomized traffic
// compared each cycle against a behavioural model of the operand stage.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1_data, rs2_data, imm;
  logic        use_imm;
  logic [1:0]  f1, f2;
  logic [31:0] exm, mwb;
  logic        is_load;
  logic        out_valid, out_ready;
  logic [31:0] op_a, op_b, store_data;
  logic [4:0]  ex_rd;
  logic        load_stall;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .id_ex_rs1(rs1), .id_ex_rs2(rs2), .id_ex_rs1_data(rs1_data), .id_ex_rs2_data(rs2_data),
    .id_ex_imm(imm), .id_ex_use_imm(use_imm), .id_ex_rd(rd),
    .rs1_forward(f1), .rs2_forward(f2),
    .ex_mem_result(exm), .ex_mem_is_load(is_load), .mem_wb_data(mwb),
    .out_valid(out_valid), .out_ready(out_ready),
    .ex_op_a(op_a), .ex_op_b(op_b), .ex_store_data(store_data), .ex_rd(ex_rd),
    .load_stall(load_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: what an operand resolves to under the forwarding rules.
  function automatic logic [31:0] resolve(input logic [4:0] idx, input logic [1:0] sel,
                                          input logic [31:0] rf);
    return (idx == 0) ? rf : (sel == 2'b01) ? exm : (sel == 2'b10) ? mwb : rf;
  endfunction

  logic        m_valid = 0, m_wait = 0, m_d1 = 0, m_d2 = 0, m_zero = 1;
  logic [31:0] m_a = 0, m_b = 0, m_sd = 0;
  logic [4:0]  m_rd = 0;
  logic        n_valid = 0, n_wait = 0, n_d1 = 0, n_d2 = 0, n_zero = 1;
  logic [31:0] n_a = 0, n_b = 0, n_sd = 0;
  logic [4:0]  n_rd = 0;

  always @(negedge clk) begin
    logic cl, hz1, hz2, e_rdy, e_stl, acc;
    logic [31:0] a, s;
    n_valid = m_valid; n_wait = m_wait; n_d1 = m_d1; n_d2 = m_d2; n_zero = m_zero;
    n_a = m_a; n_b = m_b; n_sd = m_sd; n_rd = m_rd;
    if (!rst) begin
      e_rdy = 0; e_stl = 0;
      n_valid = 0; n_wait = 0; n_d1 = 0; n_d2 = 0; n_zero = 1;
      n_a = 0; n_b = 0; n_sd = 0; n_rd = 0;
    end else begin
      cl  = !m_valid || out_ready;
      a   = (m_wait && m_d1) ? mwb : resolve(rs1, f1, rs1_data);
      s   = (m_wait && m_d2) ? mwb : resolve(rs2, f2, rs2_data);
      hz1 = !m_wait && in_valid && f1 == 2'b01 && is_load && rs1 != 0;
      hz2 = !m_wait && in_valid && f2 == 2'b01 && is_load && rs2 != 0;
      if (flush)       begin e_rdy = 0;                 e_stl = 0;         end
      else if (m_wait) begin e_rdy = cl;                e_stl = !cl;       end
      else             begin e_rdy = (hz1 || hz2) ? 0 : cl; e_stl = hz1 || hz2; end
      acc = in_valid && e_rdy;
      if (flush) begin
        n_valid = 0; n_wait = 0; n_d1 = 0; n_d2 = 0;
      end else begin
        if (m_wait && cl)             begin n_wait = 0; n_d1 = 0;   n_d2 = 0;   end
        else if (!m_wait && (hz1 || hz2)) begin n_wait = 1; n_d1 = hz1; n_d2 = hz2; end
        if (acc) begin
          n_valid = 1; n_zero = 0; n_a = a; n_b = use_imm ? imm : s; n_sd = s; n_rd = rd;
        end else if (out_ready) begin
          n_valid = 0;
        end
      end
    end
    chk("in_ready", {31'b0, in_ready}, {31'b0, e_rdy});
    chk("load_stall", {31'b0, load_stall}, {31'b0, e_stl});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    if (m_valid || m_zero) begin
      chk("ex_op_a", op_a, m_a);
      chk("ex_op_b", op_b, m_b);
      chk("ex_store_data", store_data, m_sd);
      chk("ex_rd", {27'b0, ex_rd}, {27'b0, m_rd});
    end
  end

  always @(posedge clk) begin
    m_valid <= n_valid; m_wait <= n_wait; m_d1 <= n_d1; m_d2 <= n_d2; m_zero <= n_zero;
    m_a <= n_a; m_b <= n_b; m_sd <= n_sd; m_rd <= n_rd;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    flush = 0; in_valid = 0; rs1 = 0; rs2 = 0; rd = 0; rs1_data = 0; rs2_data = 0;
    imm = 0; use_imm = 0; f1 = 0; f2 = 0; exm = 0; mwb = 0; is_load = 0; out_ready = 1;
  endtask

  initial begin
    logic hold;
    rst = 0; idle(); in_valid = 1;
    tick(); tick();
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst load_stall", {31'b0, load_stall}, 32'd0);
    chk("rst op_a", op_a, 32'd0);
    chk("rst ex_rd", {27'b0, ex_rd}, 32'd0);
    rst = 1;

    // Forwarding mux
    idle(); in_valid = 1; rs1 = 5; f1 = 2'b01; exm = 32'hAA; rs2 = 6; f2 = 2'b10;
    mwb = 32'hBB; rd = 7;
    #1 chk("fwd in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("fwd out_valid", {31'b0, out_valid}, 32'd1);
    chk("fwd op_a", op_a, 32'hAA);
    chk("fwd op_b", op_b, 32'hBB);
    chk("fwd rd", {27'b0, ex_rd}, 32'd7);

    // x0 guard
    rs1 = 0; f1 = 2'b01; rs1_data = 0;
    tick();
    chk("x0 op_a", op_a, 32'd0);
    rs1 = 4; f1 = 2'b11; rs1_data = 32'h55;
    tick();
    chk("sel11 op_a", op_a, 32'h55);

    // Load-use stall
    rs1 = 3; f1 = 2'b01; is_load = 1; rs2 = 0; f2 = 0;
    #1 chk("lu stall", {31'b0, load_stall}, 32'd1);
    chk("lu in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    mwb = 32'h1234; is_load = 0;
    #1 chk("lu wait stall", {31'b0, load_stall}, 32'd0);
    chk("lu wait ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("lu op_a", op_a, 32'h1234);
    chk("lu out_valid", {31'b0, out_valid}, 32'd1);
    in_valid = 0;
    tick();

    // Backpressure
    in_valid = 1; rs1 = 2; f1 = 2'b00; rs1_data = 32'h66; rd = 9;
    tick();
    chk("bp first op_a", op_a, 32'h66);
    out_ready = 0; rs1_data = 32'h77;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp in_ready", {31'b0, in_ready}, 32'd0);
      tick();
      chk("bp hold op_a", op_a, 32'h66);
      chk("bp hold valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1;
    #1 chk("bp release ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("bp new op_a", op_a, 32'h77);

    // Flush during LD_WAIT
    rs1 = 0; f1 = 0; use_imm = 1; imm = 32'h10; rs2 = 4; f2 = 2'b01; is_load = 1;
    #1 chk("fl stall", {31'b0, load_stall}, 32'd1);
    tick();
    flush = 1;
    #1 chk("fl in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    flush = 0; in_valid = 0;
    #1 chk("fl out_valid", {31'b0, out_valid}, 32'd0);
    chk("fl load_stall", {31'b0, load_stall}, 32'd0);
    in_valid = 1;
    #1 chk("fl back in run", {31'b0, load_stall}, 32'd1);
    tick();
    idle();
    tick();

    // Randomized traffic; an unaccepted op is held stable by upstream.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hold = rst && !flush && in_valid && !in_ready;
      @(posedge clk);
      #1;
      rst       = ($urandom_range(0, 63) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      exm       = $urandom;
      mwb       = $urandom;
      is_load   = ($urandom_range(0, 2) == 0);
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 31));
        f1  = 2'($urandom_range(0, 3));
        f2  = 2'($urandom_range(0, 3));
        rs1_data = $urandom;
        rs2_data = $urandom;
        imm      = $urandom;
        use_imm  = $urandom_range(0, 1) != 0;
      end
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
